kbd_seg_ctrl: RTL

Consumes the PS/2 scan-code byte stream from the keyboard receiver and interprets make, break and extended codes. It tracks the held key and a decimal press count. It drives six 7-segment digits: two for the current scan code and two for the press count. The remaining two are reserved and blanked. It sits between the PS/2 receiver FIFO and the board segment outputs, and instantiates the existing bcd7seg decoder per digit.

---
 rtl/kbd_pkg.sv | 19 +
 rtl/bcd7seg.sv | 34 +++
 rtl/bcd_cnt2.sv | 39 +++
 rtl/kbd_seg_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants and state encoding for the keyboard display controller
// Contents:
//   BRK_CODE, EXT_CODE - PS/2 break and extended prefix bytes
//   BLANK_SEG, SEG_ZERO - segment patterns for a dark digit and for "0"
//   kbd_state_t - IDLE / HELD / BRK interpreter states
package kbd_pkg;

    localparam logic [7:0] BRK_CODE  = 8'hF0;
    localparam logic [7:0] EXT_CODE  = 8'hE0;
    localparam logic [7:0] BLANK_SEG = 8'h00;
    localparam logic [7:0] SEG_ZERO  = 8'hFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        BRK  = 2'd2
    } kbd_state_t;

endpackage

// File: rtl/bcd7seg.sv
// rtl/bcd7seg.sv - hex nibble to 7-segment pattern decoder
// Ports:
//   bcd [3:0] in  - nibble to display (0-9 and A-F)
//   seg [7:0] out - active-high segments {a,b,c,d,e,f,g,dp}; dp always off
module bcd7seg (
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Scan codes are shown in hex, so A-F are decoded as well as 0-9.
    always_comb begin
        seg = 8'h00;
        case (bcd)
            4'h0: seg = 8'hFC;
            4'h1: seg = 8'h60;
            4'h2: seg = 8'hDA;
            4'h3: seg = 8'hF2;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'hB6;
            4'h6: seg = 8'hBE;
            4'h7: seg = 8'hE0;
            4'h8: seg = 8'hFE;
            4'h9: seg = 8'hF6;
            4'hA: seg = 8'hEE;
            4'hB: seg = 8'h3E;
            4'hC: seg = 8'h9C;
            4'hD: seg = 8'h7A;
            4'hE: seg = 8'h9E;
            4'hF: seg = 8'h8E;
            default: seg = 8'h00;
        endcase
    end

endmodule

// File: rtl/bcd_cnt2.sv
// rtl/bcd_cnt2.sv - two-digit wrapping BCD counter (00..99..00)
// Ports:
//   clk       in  - rising-edge clock
//   rst_n     in  - synchronous active-low reset, clears to 00
//   inc       in  - advance the count by one on this edge
//   cnt [7:0] out - {tens,ones} BCD digits
module bcd_cnt2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [7:0] cnt
);

    logic [3:0] ones;
    logic [3:0] tens;

    // Compares use >= 9 so a disturbed register can never hold a non-BCD
    // nibble for longer than one increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (inc) begin
            if (ones >= 4'd9) begin
                ones <= 4'd0;
                if (tens >= 4'd9) begin
                    tens <= 4'd0;
                end else begin
                    tens <= tens + 4'd1;
                end
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

    assign cnt = {tens, ones};

endmodule

// File: rtl/kbd_seg_ctrl.sv
// rtl/kbd_seg_ctrl.sv - PS/2 scan-code interpreter driving a six-digit 7-segment display
// Ports:
//   clk               in  - rising-edge clock
//   rst_n             in  - synchronous active-low reset
//   code_i [7:0]      in  - scan-code byte from the receiver
//   valid_i           in  - code_i valid
//   ready_o           out - byte accepted when valid_i && ready_o
//   key_held_o        out - a key is currently held
//   key_code_o [7:0]  out - last make code, 00 when none held
//   press_cnt_o [7:0] out - BCD press count {tens,ones}
//   seg0_o..seg5_o    out - digit patterns: code lo/hi, count ones/tens, two reserved
module kbd_seg_ctrl
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       key_held_o,
    output logic [7:0] key_code_o,
    output logic [7:0] press_cnt_o,
    output logic [7:0] seg0_o,
    output logic [7:0] seg1_o,
    output logic [7:0] seg2_o,
    output logic [7:0] seg3_o,
    output logic [7:0] seg4_o,
    output logic [7:0] seg5_o
);

    kbd_state_t state;
    kbd_state_t next_state;
    logic       ready;
    logic       accept;
    logic [7:0] key_code;
    logic       load_code;
    logic       clear_code;
    logic       cnt_inc;
    logic       show_code;
    logic [7:0] seg_code_lo;
    logic [7:0] seg_code_hi;

    assign accept = valid_i && ready;

    // Ready drops only while reset is applied; the first edge after release
    // still sees it low, so no byte is taken on that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_code  = 1'b0;
        clear_code = 1'b0;
        cnt_inc    = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (code_i == BRK_CODE) begin
                        next_state = BRK;
                    end else if (code_i != EXT_CODE) begin
                        next_state = HELD;
                        load_code  = 1'b1;
                        cnt_inc    = 1'b1;
                    end
                end
                HELD: begin
                    // Same code again is typematic repeat and is not counted;
                    // a different make code is a rollover to a new key.
                    if (code_i == BRK_CODE) begin
                        next_state = BRK;
                    end else if (code_i != EXT_CODE && code_i != key_code) begin
                        load_code = 1'b1;
                        cnt_inc   = 1'b1;
                    end
                end
                BRK: begin
                    // The released code is not matched against the held key.
                    if (code_i != BRK_CODE && code_i != EXT_CODE) begin
                        next_state = IDLE;
                        clear_code = 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    clear_code = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        key_held_o = 1'b0;
        show_code  = 1'b0;
        if (state == HELD) begin
            key_held_o = 1'b1;
            show_code  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_code <= 8'h00;
        end else if (clear_code) begin
            key_code <= 8'h00;
        end else if (load_code) begin
            key_code <= code_i;
        end
    end

    bcd_cnt2 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .cnt   (press_cnt_o)
    );

    bcd7seg u_seg_code_lo (.bcd(key_code[3:0]),    .seg(seg_code_lo));
    bcd7seg u_seg_code_hi (.bcd(key_code[7:4]),    .seg(seg_code_hi));
    bcd7seg u_seg_cnt_lo  (.bcd(press_cnt_o[3:0]), .seg(seg2_o));
    bcd7seg u_seg_cnt_hi  (.bcd(press_cnt_o[7:4]), .seg(seg3_o));

    assign seg0_o     = show_code ? seg_code_lo : BLANK_SEG;
    assign seg1_o     = show_code ? seg_code_hi : BLANK_SEG;
    assign seg4_o     = BLANK_SEG;
    assign seg5_o     = BLANK_SEG;
    assign ready_o    = ready;
    assign key_code_o = key_code;

endmodule
